// File: rtl/lpf_sweep_sequencer.sv
// Stepped-frequency sweep sequencer for the 3-stage LPF chain: program FTW, settle, sample, emit.
// Optional LPF_SWEEP_AVG_EN: four conversions per point, averaged into res_data.
module lpf_sweep_sequencer #(
    parameter int FTW_W    = 24,
    parameter int NPTS_W   = 8,
    parameter int SETTLE_W = 16,
    parameter int DATA_W   = 16
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                start,
    input  logic                abort,
    input  logic [FTW_W-1:0]    cfg_ftw_start,
    input  logic [FTW_W-1:0]    cfg_ftw_step,
    input  logic [NPTS_W-1:0]   cfg_npts,
    input  logic [SETTLE_W-1:0] cfg_settle,
    output logic [FTW_W-1:0]    ftw,
    output logic                src_en,
    output logic                adc_req,
    input  logic                adc_ack,
    input  logic [DATA_W-1:0]   adc_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [NPTS_W-1:0]   res_index,
    output logic [DATA_W-1:0]   res_data,
    output logic                busy,
    output logic                done,
    output logic                err_ovf
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EMIT, S_NEXT
    } state_t;

    state_t              state_q, state_d;
    logic [FTW_W-1:0]    ftw_q, ftw_d;
    logic [FTW_W-1:0]    ftw_start_q, ftw_start_d;
    logic [FTW_W-1:0]    step_q, step_d;
    logic [NPTS_W-1:0]   npts_q, npts_d;
    logic [NPTS_W-1:0]   index_q, index_d;
    logic [SETTLE_W-1:0] settle_cfg_q, settle_cfg_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                src_en_q, src_en_d;
    logic                adc_req_q, adc_req_d;
    logic                res_valid_q, res_valid_d;
    logic                done_q, done_d;
    logic                err_ovf_q, err_ovf_d;
    logic [FTW_W:0]      ftw_sum;

`ifdef LPF_SWEEP_AVG_EN
    logic [DATA_W+1:0]   acc_q, acc_d;
    logic [DATA_W+1:0]   acc_sum;
    logic [1:0]          cnv_q, cnv_d;

    assign acc_sum = acc_q + {2'b00, adc_data};
`endif

    // Top bit of the widened sum is the wrap indication for err_ovf.
    assign ftw_sum = {1'b0, ftw_q} + {1'b0, step_q};

    always_comb begin
        state_d      = state_q;
        ftw_d        = ftw_q;
        ftw_start_d  = ftw_start_q;
        step_d       = step_q;
        npts_d       = npts_q;
        index_d      = index_q;
        settle_cfg_d = settle_cfg_q;
        settle_d     = settle_q;
        res_data_d   = res_data_q;
        src_en_d     = src_en_q;
        adc_req_d    = adc_req_q;
        res_valid_d  = res_valid_q;
        done_d       = 1'b0;
        err_ovf_d    = err_ovf_q;
`ifdef LPF_SWEEP_AVG_EN
        acc_d        = acc_q;
        cnv_d        = cnv_q;
`endif
        if (abort) begin
            state_d     = S_IDLE;
            src_en_d    = 1'b0;
            adc_req_d   = 1'b0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_npts != '0) begin
                            ftw_start_d  = cfg_ftw_start;
                            step_d       = cfg_ftw_step;
                            npts_d       = cfg_npts;
                            settle_cfg_d = cfg_settle;
                            err_ovf_d    = 1'b0;
                            state_d      = S_LOAD;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    ftw_d    = ftw_start_q;
                    index_d  = '0;
                    src_en_d = 1'b1;
                    settle_d = settle_cfg_q;
                    state_d  = S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == '0) begin
                        state_d   = S_SAMPLE;
                        adc_req_d = 1'b1;
`ifdef LPF_SWEEP_AVG_EN
                        acc_d     = '0;
                        cnv_d     = '0;
`endif
                    end else begin
                        settle_d = settle_q - SETTLE_W'(1);
                    end
                end
                S_SAMPLE: begin
`ifdef LPF_SWEEP_AVG_EN
                    // The one-cycle request gap between conversions falls out of
                    // re-raising adc_req only when it was low the previous cycle.
                    if (adc_req_q && adc_ack) begin
                        adc_req_d = 1'b0;
                        acc_d     = acc_sum;
                        if (cnv_q == 2'd3) begin
                            res_data_d  = acc_sum[DATA_W+1:2];
                            res_valid_d = 1'b1;
                            state_d     = S_EMIT;
                        end else begin
                            cnv_d = cnv_q + 2'd1;
                        end
                    end else if (!adc_req_q) begin
                        adc_req_d = 1'b1;
                    end
`else
                    if (adc_req_q && adc_ack) begin
                        res_data_d  = adc_data;
                        adc_req_d   = 1'b0;
                        res_valid_d = 1'b1;
                        state_d     = S_EMIT;
                    end
`endif
                end
                S_EMIT: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        if (index_q == npts_q - NPTS_W'(1)) begin
                            state_d  = S_IDLE;
                            done_d   = 1'b1;
                            src_en_d = 1'b0;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    ftw_d    = ftw_sum[FTW_W-1:0];
                    if (ftw_sum[FTW_W]) err_ovf_d = 1'b1;
                    index_d  = index_q + NPTS_W'(1);
                    settle_d = settle_cfg_q;
                    state_d  = S_SETTLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_IDLE;
            ftw_q        <= '0;
            ftw_start_q  <= '0;
            step_q       <= '0;
            npts_q       <= '0;
            index_q      <= '0;
            settle_cfg_q <= '0;
            settle_q     <= '0;
            res_data_q   <= '0;
            src_en_q     <= 1'b0;
            adc_req_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            err_ovf_q    <= 1'b0;
`ifdef LPF_SWEEP_AVG_EN
            acc_q        <= '0;
            cnv_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ftw_q        <= ftw_d;
            ftw_start_q  <= ftw_start_d;
            step_q       <= step_d;
            npts_q       <= npts_d;
            index_q      <= index_d;
            settle_cfg_q <= settle_cfg_d;
            settle_q     <= settle_d;
            res_data_q   <= res_data_d;
            src_en_q     <= src_en_d;
            adc_req_q    <= adc_req_d;
            res_valid_q  <= res_valid_d;
            done_q       <= done_d;
            err_ovf_q    <= err_ovf_d;
`ifdef LPF_SWEEP_AVG_EN
            acc_q        <= acc_d;
            cnv_q        <= cnv_d;
`endif
        end
    end

    assign ftw       = ftw_q;
    assign src_en    = src_en_q;
    assign adc_req   = adc_req_q;
    assign res_valid = res_valid_q;
    assign res_index = index_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_lpf_sweep_sequencer.sv
// Scoreboard bench for lpf_sweep_sequencer: an ADC responder pushes expected results
// computed from the sweep arithmetic; a monitor pops and compares on each result handshake.
module tb_lpf_sweep_sequencer;
    localparam int FTW_W = 24, NPTS_W = 8, SETTLE_W = 16, DATA_W = 16;
    localparam int LIMIT = 3000;

    logic clk = 1'b0, nreset = 1'b0, start = 1'b0;
    logic abort_main = 1'b0, abort_resp = 1'b0, abort;
    logic [FTW_W-1:0] cfg_ftw_start = '0, cfg_ftw_step = '0;
    logic [NPTS_W-1:0] cfg_npts = '0;
    logic [SETTLE_W-1:0] cfg_settle = '0;
    logic [FTW_W-1:0] ftw;
    logic src_en, adc_req, adc_ack = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic res_valid, res_ready = 1'b0;
    logic [NPTS_W-1:0] res_index;
    logic [DATA_W-1:0] res_data;
    logic busy, done, err_ovf;

    assign abort = abort_main | abort_resp;

    lpf_sweep_sequencer #(.FTW_W(FTW_W), .NPTS_W(NPTS_W), .SETTLE_W(SETTLE_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .nreset(nreset), .start(start), .abort(abort),
        .cfg_ftw_start(cfg_ftw_start), .cfg_ftw_step(cfg_ftw_step), .cfg_npts(cfg_npts), .cfg_settle(cfg_settle),
        .ftw(ftw), .src_en(src_en), .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index), .res_data(res_data),
        .busy(busy), .done(done), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_fail = 0;
    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { int idx; int data; } exp_t;
    exp_t exp_q[$];

    // sweep model, owned by the main thread
    longint m_start = 0, m_step = 0;
    int m_npts = 0, sweep_no = 0;
    int auto_en = 1, ack_delay = 2, ack_abort = 0, data_mode = 0, rr_mode = 1;

    // owned by the responder / monitor
    int n_acks = 0, abort_cnt = 0, abort_cyc = 0, n_res = 0;

    function automatic longint model_ftw(input int i);
        return (m_start + longint'(i) * m_step) % (64'd1 << FTW_W);
    endfunction

    // ADC responder: acks after ack_delay cycles and predicts the result for the point
    initial begin
        int wcnt, pt_idx, nsamp, seen_sweep, d, sum, ack_q;
        wcnt = 0; pt_idx = 0; nsamp = 0; seen_sweep = 0; sum = 0; ack_q = 0;
        forever begin
            @(negedge clk);
            if (sweep_no != seen_sweep) begin
                seen_sweep = sweep_no; pt_idx = 0; nsamp = 0; sum = 0;
            end
            if (ack_q != 0) begin
                adc_ack = 1'b0; abort_resp = 1'b0; ack_q = 0; wcnt = 0;
            end else if (auto_en != 0 && adc_req) begin
                if (wcnt >= ack_delay) begin
                    d = (data_mode != 0) ? 10 + (nsamp % 4) : int'($urandom_range(0, 65535));
                    adc_ack = 1'b1; adc_data = d[DATA_W-1:0]; ack_q = 1; n_acks++;
                    if (ack_abort != 0) begin
                        abort_resp = 1'b1; abort_cnt++; abort_cyc = cyc;
                    end else begin
                        chk("ftw_at_sample", ftw, model_ftw(pt_idx));
                        chk("src_en_at_sample", src_en, 1);
`ifdef LPF_SWEEP_AVG_EN
                        sum += d; nsamp++;
                        if (nsamp % 4 == 0) begin
                            exp_q.push_back('{pt_idx, sum / 4}); sum = 0; pt_idx++;
                        end
`else
                        exp_q.push_back('{pt_idx, d}); pt_idx++;
`endif
                    end
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    // Monitor: owns res_ready; a handshake happens on the next edge when both are high
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            case (rr_mode)
                0: res_ready = 1'b0;
                1: res_ready = 1'b1;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
            if (nreset && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_index", res_index, e.idx);
                    chk("res_data", res_data, e.data);
                end
                n_res++;
            end
        end
    end

    task automatic pulse_start(input longint fs, input longint st, input int np, input int se);
        m_start = fs; m_step = st; m_npts = np; sweep_no++;
        cfg_ftw_start = fs[FTW_W-1:0]; cfg_ftw_step = st[FTW_W-1:0];
        cfg_npts = np[NPTS_W-1:0]; cfg_settle = se[SETTLE_W-1:0];
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_sweep(input longint fs, input longint st, input int np, input int se);
        int base, lat, k;
        base = n_res;
        pulse_start(fs, st, np, se);
        if (np == 0) begin
            chk("npts0_done", done, 1);
            chk("npts0_busy", busy, 0);
            @(negedge clk);
            chk("npts0_done_width", done, 0);
            chk("npts0_quiet", {busy, src_en, adc_req}, 0);
            return;
        end
        // shadowed config: scrambling the inputs must not disturb the sweep
        cfg_ftw_start = FTW_W'($urandom); cfg_ftw_step = FTW_W'($urandom);
        cfg_npts = NPTS_W'($urandom); cfg_settle = SETTLE_W'($urandom_range(0, 3));
        lat = 1;
        while (!adc_req && lat < LIMIT) begin @(negedge clk); lat++; end
        chk("first_req_latency", lat - 1, 2 + se);
        chk("err_ovf_cleared_by_start", err_ovf, 0);
        k = 0;
        while (!done && k < LIMIT) begin
            @(negedge clk); k++;
            if (k == 5 && !done) start = 1'b1;
            if (k == 6) start = 1'b0;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("busy_falls_with_done", busy, 0);
        chk("src_en_off_at_done", src_en, 0);
        chk("result_count", n_res - base, np);
        chk("err_ovf", err_ovf, (fs + longint'(np - 1) * st) >= (64'd1 << FTW_W));
        @(negedge clk);
        chk("done_width", done, 0);
    endtask

    initial begin
        int base, k, ed, seen, acks0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {ftw, src_en, adc_req, res_valid, res_index, res_data, busy, done, err_ovf}, 0);
        nreset = 1'b1;
        @(negedge clk);

        // basic three-point sweep
        ack_delay = 2; rr_mode = 1;
        run_sweep(24'h000100, 24'h000080, 3, 4);

        // empty sweep
        run_sweep(24'h001000, 24'h000010, 0, 3);

        // result back-pressure
        base = n_res; rr_mode = 0; ed = -1;
        pulse_start(24'h002000, 24'h000100, 2, 3);
        k = 0;
        while (!res_valid && k < LIMIT) begin @(negedge clk); k++; end
        chk("stall_res_valid_seen", res_valid, 1);
        if (exp_q.size() > 0) ed = exp_q[0].data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_res_valid", res_valid, 1);
            chk("stall_res_index", res_index, 0);
            chk("stall_res_data", res_data, ed);
            chk("stall_no_req", adc_req, 0);
        end
        rr_mode = 1;
        k = 0;
        while (!done && k < LIMIT) begin @(negedge clk); k++; end
        chk("stall_done", done, 1);
        chk("stall_count", n_res - base, 2);

        // FTW wrap sets the sticky error, the next start clears it
        run_sweep(24'hFFFF00, 24'h000200, 2, 1);
        @(negedge clk);
        chk("err_ovf_sticky", err_ovf, 1);
        run_sweep(24'h000300, 24'h000010, 2, 0);

        // abort mid-SETTLE of point 1 (after a wrap, so err_ovf must survive)
        base = n_res;
        pulse_start(24'hFFFF80, 24'h000100, 3, 10);
        k = 0;
        while (n_res == base && k < LIMIT) begin @(negedge clk); k++; end
        repeat (4) @(negedge clk);
        chk("abortA_in_settle", {busy, adc_req, res_valid}, 3'b100);
        abort_main = 1'b1;
        @(negedge clk);
        abort_main = 1'b0;
        chk("abortA_idle", {busy, src_en, adc_req, res_valid, done}, 0);
        chk("abortA_err_ovf_kept", err_ovf, 1);
        seen = 0;
        repeat (6) begin @(negedge clk); seen |= int'({busy, done, res_valid, adc_req}); end
        chk("abortA_quiet", seen, 0);
        chk("abortA_results", n_res - base, 1);

        // abort in the same cycle as adc_ack
        base = n_res; ack_abort = 1; k = 0; seen = abort_cnt;
        pulse_start(24'h004000, 24'h000040, 2, 1);
        while (!(abort_cnt != seen && cyc == abort_cyc + 1) && k < LIMIT) begin @(negedge clk); k++; end
        ack_abort = 0;
        chk("abortB_fired", abort_cnt - seen, 1);
        chk("abortB_idle", {busy, src_en, adc_req, res_valid, done}, 0);
        seen = 0;
        repeat (6) begin @(negedge clk); seen |= int'({busy, done, res_valid, adc_req}); end
        chk("abortB_quiet", seen, 0);
        chk("abortB_results", n_res - base, 0);

`ifdef LPF_SWEEP_AVG_EN
        // four-sample averaging: 10,11,12,13 -> 11
        data_mode = 1; acks0 = n_acks;
        run_sweep(24'h010000, 24'h000100, 1, 2);
        chk("avg_ack_count", n_acks - acks0, 4);
        data_mode = 0;
`else
        acks0 = n_acks;
        run_sweep(24'h010000, 24'h000100, 1, 2);
        chk("single_ack_count", n_acks - acks0, 1);
`endif

        // randomized sweeps with random back-pressure
        rr_mode = 2;
        for (int i = 0; i < 8; i++) begin
            ack_delay = $urandom_range(0, 3);
            run_sweep(longint'($urandom_range(0, 24'hFFFFFF)), longint'($urandom_range(0, 24'hFFFFFF)),
                      $urandom_range(1, 5), $urandom_range(0, 6));
        end
        rr_mode = 1;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d required completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
